// File: rtl/cnt_distributor_pkg.sv
// Shared defaults and select encodings for the counter distributor.
// Pure definitions: no latency, no backpressure.
package cnt_distributor_pkg;

    localparam int WIDTH_DEF       = 4;
    localparam int DEPTH_DEF       = 2;
    localparam int TALLY_W_DEF     = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic SEL_CNT1 = 1'b0;
    localparam logic SEL_CNT2 = 1'b1;

    // A one-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cnt_distributor_if.sv
// Counter stream in, two buffered channel streams out, plus tallies and select.
// Valid/ready on every stream; the slave side is the distributor.
interface cnt_distributor_if #(
    parameter int WIDTH   = 4,
    parameter int TALLY_W = 8
);
    logic [WIDTH-1:0]   cnt;
    logic               cnt_valid;
    logic               cnt_ready;
    logic [WIDTH-1:0]   cnt1;
    logic               cnt1_valid;
    logic               cnt1_ready;
    logic [WIDTH-1:0]   cnt2;
    logic               cnt2_valid;
    logic               cnt2_ready;
    logic [TALLY_W-1:0] tally1;
    logic [TALLY_W-1:0] tally2;
    logic               sel;

    modport master (
        output cnt, cnt_valid, cnt1_ready, cnt2_ready,
        input  cnt_ready, cnt1, cnt1_valid, cnt2, cnt2_valid, tally1, tally2, sel
    );

    modport slave (
        input  cnt, cnt_valid, cnt1_ready, cnt2_ready,
        output cnt_ready, cnt1, cnt1_valid, cnt2, cnt2_valid, tally1, tally2, sel
    );
endinterface

// File: rtl/cnt_fifo.sv
// Small synchronous FIFO; pushed word is visible at the head the next cycle.
// Push ignored when full, pop ignored when empty; head reads 0 when empty.
module cnt_fifo
    import cnt_distributor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Full blocks push even with a same-cycle pop: no pass-through.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = dat_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/cnt_distributor.sv
// Steers one counter stream into one of two FIFO channels chosen by synchronized SW; 1-cycle latency.
// CNT_READY is ~full of the selected channel, from registers only; each channel drains independently.
module cnt_distributor
    import cnt_distributor_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int TALLY_W     = TALLY_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SW,
    cnt_distributor_if.slave   bus
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TALLY_W-1:0]     tally1_q, tally1_d, tally2_q, tally2_d;
    logic                   sel;
    logic                   full1, full2, empty1, empty2;
    logic                   push, push1, push2;

    // SW is a raw board switch; SEL is its last synchronizer stage.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], SW};
    assign sel    = sync_q[SYNC_STAGES-1];

    assign bus.sel       = sel;
    assign bus.cnt_ready = (sel == SEL_CNT2) ? ~full2 : ~full1;

    assign push  = bus.cnt_valid & bus.cnt_ready;
    assign push1 = push & (sel == SEL_CNT1);
    assign push2 = push & (sel == SEL_CNT2);

    always_comb begin
        tally1_d = tally1_q;
        tally2_d = tally2_q;
        if (push1) tally1_d = tally1_q + TALLY_W'(1);
        if (push2) tally2_d = tally2_q + TALLY_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q   <= '0;
            tally1_q <= '0;
            tally2_q <= '0;
        end else begin
            sync_q   <= sync_d;
            tally1_q <= tally1_d;
            tally2_q <= tally2_d;
        end
    end

    assign bus.tally1     = tally1_q;
    assign bus.tally2     = tally2_q;
    assign bus.cnt1_valid = ~empty1;
    assign bus.cnt2_valid = ~empty2;

    cnt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (CLK),
        .rst_n   (RST),
        .push_i  (push1),
        .pop_i   (bus.cnt1_ready),
        .dat_i   (bus.cnt),
        .head_o  (bus.cnt1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    cnt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk     (CLK),
        .rst_n   (RST),
        .push_i  (push2),
        .pop_i   (bus.cnt2_ready),
        .dat_i   (bus.cnt),
        .head_o  (bus.cnt2),
        .full_o  (full2),
        .empty_o (empty2)
    );
endmodule

// File: tb/tb_cnt_distributor.sv
// Directed bench for cnt_distributor with a per-channel expected-data queue.
module tb_cnt_distributor;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    logic sw;

    cnt_distributor_if #(.WIDTH(4), .TALLY_W(8)) bus ();

    cnt_distributor dut (
        .CLK (clk),
        .RST (rst),
        .SW  (sw),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0] q1[$];
    logic [3:0] q2[$];
    logic [7:0] m_tally1, m_tally2;
    logic       s0, s1;
    int         acc_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q2.delete();
        m_tally1  = '0;
        m_tally2  = '0;
        s0        = 1'b0;
        s1        = 1'b0;
        acc_total = 0;
    endtask

    // One clock: compare at negedge, advance the model, return #1 after posedge.
    task automatic cycle(output bit acc);
        bit         rdy;
        logic [3:0] e1, e2;
        @(negedge clk);
        rdy = s1 ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
        e1  = '0;
        e2  = '0;
        if (q1.size() != 0) e1 = q1[0];
        if (q2.size() != 0) e2 = q2[0];
        check("sel", 32'(bus.sel), 32'(s1));
        check("cnt_ready", 32'(bus.cnt_ready), 32'(rdy));
        check("cnt1_valid", 32'(bus.cnt1_valid), 32'(q1.size() != 0));
        check("cnt1", 32'(bus.cnt1), 32'(e1));
        check("cnt2_valid", 32'(bus.cnt2_valid), 32'(q2.size() != 0));
        check("cnt2", 32'(bus.cnt2), 32'(e2));
        check("tally1", 32'(bus.tally1), 32'(m_tally1));
        check("tally2", 32'(bus.tally2), 32'(m_tally2));
        acc = bus.cnt_valid && rdy;
        if (bus.cnt1_ready && q1.size() != 0) void'(q1.pop_front());
        if (bus.cnt2_ready && q2.size() != 0) void'(q2.pop_front());
        if (acc) begin
            acc_total++;
            if (s1) begin
                q2.push_back(bus.cnt);
                m_tally2 = m_tally2 + 8'd1;
            end else begin
                q1.push_back(bus.cnt);
                m_tally1 = m_tally1 + 8'd1;
            end
        end
        s1 = s0;
        s0 = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        sw            = 1'b0;
        bus.cnt_valid = 1'b0;
        #2;
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_cnt_ready", 32'(bus.cnt_ready), 32'd1);
        check("rst_cnt1", 32'(bus.cnt1), 32'd0);
        check("rst_cnt2", 32'(bus.cnt2), 32'd0);
        check("rst_cnt1_valid", 32'(bus.cnt1_valid), 32'd0);
        check("rst_cnt2_valid", 32'(bus.cnt2_valid), 32'd0);
        check("rst_tally1", 32'(bus.tally1), 32'd0);
        check("rst_tally2", 32'(bus.tally2), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit acc;
        int n;
        int guard;

        rst            = 1'b0;
        sw             = 1'b0;
        bus.cnt        = '0;
        bus.cnt_valid  = 1'b0;
        bus.cnt1_ready = 1'b0;
        bus.cnt2_ready = 1'b0;
        model_clear();
        do_reset();

        // Two words to channel 1 with a ready consumer.
        bus.cnt1_ready = 1'b1;
        bus.cnt2_ready = 1'b1;
        bus.cnt_valid  = 1'b1;
        bus.cnt = 4'd3; cycle(acc); check("s2_acc3", 32'(acc), 32'd1);
        bus.cnt = 4'd4; cycle(acc); check("s2_acc4", 32'(acc), 32'd1);
        bus.cnt_valid = 1'b0;
        idle(3);
        check("s2_tally1", 32'(bus.tally1), 32'd2);
        check("s2_tally2", 32'(bus.tally2), 32'd0);

        // Reset while channel 1 holds data.
        bus.cnt1_ready = 1'b0;
        bus.cnt_valid  = 1'b1;
        bus.cnt = 4'd7;
        idle(2);
        do_reset();

        // Stall channel 1, then redirect the stalled word by flipping SW.
        bus.cnt1_ready = 1'b0;
        bus.cnt2_ready = 1'b0;
        bus.cnt_valid  = 1'b1;
        bus.cnt = 4'd1; cycle(acc); check("s3_acc1", 32'(acc), 32'd1);
        bus.cnt = 4'd2; cycle(acc); check("s3_acc2", 32'(acc), 32'd1);
        bus.cnt = 4'd3; cycle(acc); check("s3_refuse", 32'(acc), 32'd0);
        sw = 1'b1;
        n = 0;
        cycle(acc);
        while (!acc && n < 8) begin
            n++;
            cycle(acc);
        end
        check("s3_wait", 32'(n), 32'd2);
        check("s3_tally2", 32'(bus.tally2), 32'd1);
        bus.cnt_valid  = 1'b0;
        bus.cnt1_ready = 1'b1;
        bus.cnt2_ready = 1'b1;
        idle(4);

        // Full channel: same-cycle pop does not let the push through.
        sw = 1'b0;
        idle(3);
        bus.cnt1_ready = 1'b0;
        bus.cnt_valid  = 1'b1;
        bus.cnt = 4'd5; cycle(acc);
        bus.cnt = 4'd6; cycle(acc);
        bus.cnt = 4'd9;
        bus.cnt1_ready = 1'b1;
        cycle(acc); check("s4_refuse", 32'(acc), 32'd0);
        cycle(acc); check("s4_accept", 32'(acc), 32'd1);
        bus.cnt_valid  = 1'b0;
        bus.cnt1_ready = 1'b0;
        idle(1);
        // Channel 1 full and popping while channel 2 accepts.
        sw = 1'b1;
        idle(2);
        bus.cnt_valid  = 1'b1;
        bus.cnt        = 4'hA;
        bus.cnt1_ready = 1'b1;
        cycle(acc); check("s4_other", 32'(acc), 32'd1);
        bus.cnt_valid  = 1'b0;
        bus.cnt2_ready = 1'b1;
        idle(4);

        // SW toggling every cycle with random traffic.
        for (int i = 0; i < 40; i++) begin
            sw             = ~sw;
            bus.cnt_valid  = ($urandom_range(0, 3) != 0);
            bus.cnt        = 4'($urandom);
            bus.cnt1_ready = 1'($urandom_range(0, 1));
            bus.cnt2_ready = 1'($urandom_range(0, 1));
            cycle(acc);
        end
        bus.cnt_valid  = 1'b0;
        bus.cnt1_ready = 1'b1;
        bus.cnt2_ready = 1'b1;
        idle(6);
        check("s5_sum", 32'(8'(bus.tally1 + bus.tally2)), 32'(8'(acc_total)));

        // 256 words into channel 1: tally wraps, order held by the queue.
        do_reset();
        sw             = 1'b0;
        bus.cnt1_ready = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 256 && guard < 600) begin
            bus.cnt_valid = 1'b1;
            bus.cnt       = 4'(n);
            cycle(acc);
            if (acc) n++;
            guard++;
        end
        bus.cnt_valid = 1'b0;
        check("s6_count", 32'(n), 32'd256);
        idle(2);
        check("s6_tally1_wrap", 32'(bus.tally1), 32'd0);
        check("s6_tally2", 32'(bus.tally2), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
